// File: rtl/mips_exec_core_if.sv
// Instruction, write-back and debug-read bundle
// shared by the execute core and its driver.
interface mips_exec_core_if;
  logic [31:0] instr;
  logic [31:0] alu_res;
  logic        reg_write_en;
  logic [4:0]  reg_w;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  modport master (
    output instr,
    output dbg_addr,
    input  alu_res,
    input  reg_write_en,
    input  reg_w,
    input  dbg_data
  );

  modport slave (
    input  instr,
    input  dbg_addr,
    output alu_res,
    output reg_write_en,
    output reg_w,
    output dbg_data
  );
endinterface

// File: rtl/mips_exec_core.sv
// Single-cycle MIPS integer execute core:
// decoder, 32x32 register file and ALU.
module mips_exec_ctrl (
  input  logic [31:0] instr,
  output logic [4:0]  rs_idx,
  output logic [4:0]  rt_idx,
  output logic        we,
  output logic [4:0]  wr_idx,
  output logic [5:0]  alu_op,
  output logic        use_imm,
  output logic [31:0] imm_ext,
  output logic [4:0]  shamt
);
  logic [5:0]  opc;
  logic [5:0]  fn;
  logic [15:0] imm;
  logic        r_ok;
  logic        sx_ok;
  logic        zx_ok;
  logic        lui_ok;
  logic [5:0]  i_op;

  assign opc    = instr[31:26];
  assign fn     = instr[5:0];
  assign imm    = instr[15:0];
  assign rs_idx = instr[25:21];
  assign rt_idx = instr[20:16];

  always_comb begin
    r_ok = 1'b0;
    if (opc == 6'h00) begin
      case (fn)
        6'h20, 6'h21, 6'h22, 6'h23,
        6'h24, 6'h25, 6'h26, 6'h27,
        6'h2A, 6'h2B,
        6'h00, 6'h02, 6'h03: r_ok = 1'b1;
        default:             r_ok = 1'b0;
      endcase
    end
  end

  assign sx_ok  = (opc >= 6'h08) && (opc <= 6'h0B);
  assign zx_ok  = (opc >= 6'h0C) && (opc <= 6'h0E);
  assign lui_ok = (opc == 6'h0F);

  // I-type opcodes map onto the R-type funct of the same operation
  always_comb begin
    i_op = 6'h3F;
    case (opc[2:0])
      3'd0:    i_op = 6'h20;
      3'd1:    i_op = 6'h21;
      3'd2:    i_op = 6'h2A;
      3'd3:    i_op = 6'h2B;
      3'd4:    i_op = 6'h24;
      3'd5:    i_op = 6'h25;
      3'd6:    i_op = 6'h26;
      default: i_op = 6'h00;
    endcase
  end

  always_comb begin
    we      = 1'b0;
    wr_idx  = 5'd0;
    alu_op  = 6'h3F;
    use_imm = 1'b0;
    imm_ext = 32'h0;
    shamt   = 5'd0;
    unique case (1'b1)
      r_ok: begin
        we     = 1'b1;
        wr_idx = instr[15:11];
        alu_op = fn;
        shamt  = instr[10:6];
      end
      sx_ok: begin
        we      = 1'b1;
        wr_idx  = rt_idx;
        alu_op  = i_op;
        use_imm = 1'b1;
        imm_ext = {{16{imm[15]}}, imm};
      end
      zx_ok: begin
        we      = 1'b1;
        wr_idx  = rt_idx;
        alu_op  = i_op;
        use_imm = 1'b1;
        imm_ext = {16'h0, imm};
      end
      // lui reuses the shifter: imm shifted left by 16
      lui_ok: begin
        we      = 1'b1;
        wr_idx  = rt_idx;
        alu_op  = i_op;
        use_imm = 1'b1;
        imm_ext = {16'h0, imm};
        shamt   = 5'd16;
      end
      default: ;
    endcase
  end
endmodule

module mips_exec_rf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  ra3,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] rd3
);
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[wa] = wd;
    regs_d[0] = 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'h0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'h0 : regs_q[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'h0 : regs_q[ra2];
  assign rd3 = (ra3 == 5'd0) ? 32'h0 : regs_q[ra3];
endmodule

module mips_exec_alu (
  input  logic [5:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  sh,
  output logic [31:0] y
);
  always_comb begin
    y = 32'h0;
    case (op)
      6'h20, 6'h21: y = a + b;
      6'h22, 6'h23: y = a - b;
      6'h24:        y = a & b;
      6'h25:        y = a | b;
      6'h26:        y = a ^ b;
      6'h27:        y = ~(a | b);
      6'h2A:        y = {31'h0, $signed(a) < $signed(b)};
      6'h2B:        y = {31'h0, a < b};
      6'h00:        y = b << sh;
      6'h02:        y = b >> sh;
      6'h03:        y = $signed(b) >>> sh;
      default:      y = 32'h0;
    endcase
  end
endmodule

module mips_exec_core (
  input logic             clk,
  input logic             reset,
  mips_exec_core_if.slave bus
);
  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;
  logic        we;
  logic [4:0]  wr_idx;
  logic [5:0]  alu_op;
  logic        use_imm;
  logic [31:0] imm_ext;
  logic [4:0]  shamt;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] alu_b;
  logic [31:0] alu_y;

  mips_exec_ctrl u_ctrl (
    .instr   (bus.instr),
    .rs_idx  (rs_idx),
    .rt_idx  (rt_idx),
    .we      (we),
    .wr_idx  (wr_idx),
    .alu_op  (alu_op),
    .use_imm (use_imm),
    .imm_ext (imm_ext),
    .shamt   (shamt)
  );

  mips_exec_rf u_rf (
    .clk   (clk),
    .rst_n (reset),
    .ra1   (rs_idx),
    .ra2   (rt_idx),
    .ra3   (bus.dbg_addr),
    .we    (we),
    .wa    (wr_idx),
    .wd    (alu_y),
    .rd1   (rs_data),
    .rd2   (rt_data),
    .rd3   (bus.dbg_data)
  );

  assign alu_b = use_imm ? imm_ext : rt_data;

  mips_exec_alu u_alu (
    .op (alu_op),
    .a  (rs_data),
    .b  (alu_b),
    .sh (shamt),
    .y  (alu_y)
  );

  assign bus.alu_res      = alu_y;
  assign bus.reg_write_en = we;
  assign bus.reg_w        = wr_idx;
endmodule

// File: tb/tb_mips_exec_core.sv
// Directed-vector bench for mips_exec_core with
// hand-computed results per instruction.
module tb_mips_exec_core;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  mips_exec_core_if bus ();

  mips_exec_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ei(
    input logic [5:0] op, input logic [4:0] rs,
    input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] er(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] rd, input logic [4:0] sh,
    input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.instr = 32'h0;
    bus.dbg_addr = 5'd0;
    #2;
    nvec++;
    if (bus.alu_res !== 32'h0 || bus.reg_write_en !== 1'b1 ||
        bus.reg_w !== 5'd0) begin
      nerr++;
      $display("FAIL reset_outputs got res=%h we=%b w=%0d want 0/1/0",
               bus.alu_res, bus.reg_write_en, bus.reg_w);
    end
    step();
    for (int r = 1; r < 32; r += 10) begin
      bus.dbg_addr = 5'(r);
      #1;
      nvec++;
      if (bus.dbg_data !== 32'h0) begin
        nerr++;
        $display("FAIL reset_reg%0d got %h want 0", r, bus.dbg_data);
      end
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_itype;
    logic [31:0] iv [5];
    logic [31:0] ev [5];
    logic [4:0]  wv [5];
    iv = '{ei(6'h08, 0, 1, 16'h0005), ei(6'h08, 0, 2, 16'hFFFF),
           ei(6'h0B, 0, 11, 16'hFFFF), ei(6'h0A, 0, 12, 16'hFFFF),
           ei(6'h09, 2, 19, 16'h0002)};
    ev = '{32'h5, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h1};
    wv = '{5'd1, 5'd2, 5'd11, 5'd12, 5'd19};
    for (int i = 0; i < 5; i++) begin
      bus.instr = iv[i];
      #1;
      nvec++;
      if ({bus.reg_write_en, bus.reg_w, bus.alu_res} !==
          {1'b1, wv[i], ev[i]}) begin
        nerr++;
        $display("FAIL itype%0d got we=%b w=%0d res=%h want 1/%0d/%h",
                 i, bus.reg_write_en, bus.reg_w, bus.alu_res, wv[i], ev[i]);
      end
      step();
      bus.dbg_addr = wv[i];
      #1;
      nvec++;
      if (bus.dbg_data !== ev[i]) begin
        nerr++;
        $display("FAIL itype%0d_wb got %h want %h", i, bus.dbg_data, ev[i]);
      end
    end
  endtask

  task automatic test_rtype;
    logic [31:0] iv [6];
    logic [31:0] ev [6];
    logic [4:0]  wv [6];
    iv = '{er(1, 2, 3, 0, 6'h20), er(1, 2, 4, 0, 6'h22),
           er(2, 1, 5, 0, 6'h2A), er(2, 1, 6, 0, 6'h2B),
           er(0, 0, 20, 0, 6'h27), er(0, 1, 21, 0, 6'h23)};
    ev = '{32'h4, 32'h6, 32'h1, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFB};
    wv = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd20, 5'd21};
    for (int i = 0; i < 6; i++) begin
      bus.instr = iv[i];
      #1;
      nvec++;
      if ({bus.reg_write_en, bus.reg_w, bus.alu_res} !==
          {1'b1, wv[i], ev[i]}) begin
        nerr++;
        $display("FAIL rtype%0d got we=%b w=%0d res=%h want 1/%0d/%h",
                 i, bus.reg_write_en, bus.reg_w, bus.alu_res, wv[i], ev[i]);
      end
      step();
      bus.dbg_addr = wv[i];
      #1;
      nvec++;
      if (bus.dbg_data !== ev[i]) begin
        nerr++;
        $display("FAIL rtype%0d_wb got %h want %h", i, bus.dbg_data, ev[i]);
      end
    end
  endtask

  task automatic test_logic_shift;
    logic [31:0] iv [9];
    logic [31:0] ev [9];
    logic [4:0]  wv [9];
    iv = '{ei(6'h0D, 0, 7, 16'hFFFF), ei(6'h0F, 0, 8, 16'h8000),
           er(1, 8, 9, 4, 6'h03), er(1, 8, 10, 4, 6'h02),
           er(0, 7, 13, 8, 6'h00), ei(6'h0C, 2, 14, 16'h8001),
           ei(6'h0E, 7, 15, 16'h00FF), er(7, 14, 22, 0, 6'h26),
           er(2, 7, 23, 0, 6'h24)};
    ev = '{32'h0000FFFF, 32'h80000000, 32'hF8000000, 32'h08000000,
           32'h00FFFF00, 32'h00008001, 32'h0000FF00, 32'h00007FFE,
           32'h0000FFFF};
    wv = '{5'd7, 5'd8, 5'd9, 5'd10, 5'd13, 5'd14, 5'd15, 5'd22, 5'd23};
    for (int i = 0; i < 9; i++) begin
      bus.instr = iv[i];
      #1;
      nvec++;
      if ({bus.reg_write_en, bus.reg_w, bus.alu_res} !==
          {1'b1, wv[i], ev[i]}) begin
        nerr++;
        $display("FAIL logic%0d got we=%b w=%0d res=%h want 1/%0d/%h",
                 i, bus.reg_write_en, bus.reg_w, bus.alu_res, wv[i], ev[i]);
      end
      step();
      bus.dbg_addr = wv[i];
      #1;
      nvec++;
      if (bus.dbg_data !== ev[i]) begin
        nerr++;
        $display("FAIL logic%0d_wb got %h want %h", i, bus.dbg_data, ev[i]);
      end
    end
  endtask

  task automatic test_zero_overflow;
    logic [31:0] iv [5];
    logic [31:0] ev [5];
    logic [4:0]  wv [5];
    bus.instr = ei(6'h08, 0, 0, 16'h0007);
    #1;
    nvec++;
    if ({bus.reg_write_en, bus.reg_w, bus.alu_res} !==
        {1'b1, 5'd0, 32'h7}) begin
      nerr++;
      $display("FAIL zero_dec got we=%b w=%0d res=%h want 1/0/7",
               bus.reg_write_en, bus.reg_w, bus.alu_res);
    end
    step();
    bus.dbg_addr = 5'd0;
    #1;
    nvec++;
    if (bus.dbg_data !== 32'h0) begin
      nerr++;
      $display("FAIL zero_reg got %h want 0", bus.dbg_data);
    end
    iv = '{ei(6'h0F, 0, 16, 16'h7FFF), ei(6'h0D, 16, 16, 16'hFFFF),
           ei(6'h08, 0, 17, 16'h0001), er(16, 17, 18, 0, 6'h20),
           ei(6'h08, 16, 24, 16'h0001)};
    ev = '{32'h7FFF0000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 32'h80000000};
    wv = '{5'd16, 5'd16, 5'd17, 5'd18, 5'd24};
    for (int i = 0; i < 5; i++) begin
      bus.instr = iv[i];
      step();
      bus.dbg_addr = wv[i];
      #1;
      nvec++;
      if (bus.dbg_data !== ev[i]) begin
        nerr++;
        $display("FAIL ovf%0d got %h want %h", i, bus.dbg_data, ev[i]);
      end
    end
  endtask

  task automatic test_no_bypass;
    bus.instr = ei(6'h08, 1, 1, 16'h0001);
    bus.dbg_addr = 5'd1;
    #1;
    nvec++;
    if (bus.dbg_data !== 32'h5 || bus.alu_res !== 32'h6) begin
      nerr++;
      $display("FAIL no_bypass got dbg=%h res=%h want 5/6",
               bus.dbg_data, bus.alu_res);
    end
    step();
    nvec++;
    if (bus.dbg_data !== 32'h6) begin
      nerr++;
      $display("FAIL no_bypass_wb got %h want 6", bus.dbg_data);
    end
  endtask

  task automatic test_unsupported;
    bus.instr = ei(6'h3F, 1, 1, 16'h1234);
    bus.dbg_addr = 5'd1;
    #1;
    nvec++;
    if ({bus.reg_write_en, bus.reg_w, bus.alu_res} !==
        {1'b0, 5'd0, 32'h0}) begin
      nerr++;
      $display("FAIL bad_opc got we=%b w=%0d res=%h want 0/0/0",
               bus.reg_write_en, bus.reg_w, bus.alu_res);
    end
    step();
    nvec++;
    if (bus.dbg_data !== 32'h6) begin
      nerr++;
      $display("FAIL bad_opc_reg got %h want 6", bus.dbg_data);
    end
    bus.instr = er(1, 2, 3, 0, 6'h01);
    bus.dbg_addr = 5'd3;
    #1;
    nvec++;
    if ({bus.reg_write_en, bus.reg_w, bus.alu_res} !==
        {1'b0, 5'd0, 32'h0}) begin
      nerr++;
      $display("FAIL bad_fn got we=%b w=%0d res=%h want 0/0/0",
               bus.reg_write_en, bus.reg_w, bus.alu_res);
    end
    step();
    nvec++;
    if (bus.dbg_data !== 32'h4) begin
      nerr++;
      $display("FAIL bad_fn_reg got %h want 4", bus.dbg_data);
    end
  endtask

  task automatic test_reset_midcycle;
    int bad;
    bus.instr = ei(6'h08, 0, 1, 16'h0009);
    bus.dbg_addr = 5'd18;
    #2;
    reset = 1'b0;
    #1;
    nvec++;
    if (bus.dbg_data !== 32'h0) begin
      nerr++;
      $display("FAIL mid_reset_r18 got %h want 0", bus.dbg_data);
    end
    nvec++;
    if ({bus.reg_write_en, bus.reg_w, bus.alu_res} !==
        {1'b1, 5'd1, 32'h9}) begin
      nerr++;
      $display("FAIL mid_reset_comb got we=%b w=%0d res=%h want 1/1/9",
               bus.reg_write_en, bus.reg_w, bus.alu_res);
    end
    bus.dbg_addr = 5'd8;
    #1;
    nvec++;
    if (bus.dbg_data !== 32'h0) begin
      nerr++;
      $display("FAIL mid_reset_r8 got %h want 0", bus.dbg_data);
    end
    step();
    bad = 0;
    for (int r = 0; r < 32; r++) begin
      bus.dbg_addr = 5'(r);
      #1;
      if (bus.dbg_data !== 32'h0) bad++;
    end
    nvec++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL reset_all got %0d nonzero regs want 0", bad);
    end
    step();
    reset = 1'b1;
    bus.dbg_addr = 5'd1;
    step();
    nvec++;
    if (bus.dbg_data !== 32'h9) begin
      nerr++;
      $display("FAIL post_reset_wb got %h want 9", bus.dbg_data);
    end
  endtask

  initial begin
    test_reset();
    test_itype();
    test_rtype();
    test_logic_shift();
    test_zero_overflow();
    test_no_bypass();
    test_unsupported();
    test_reset_midcycle();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mips_exec_core.md
MIPS_EXEC_CORE -- requirements
Module: mips_exec_core

Interface
REQ-001 Parameters: none; register count fixed at 32, data width fixed at 32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low; low clears the register file immediately.
REQ-004 instr  input  32  current MIPS instruction; combinational, held stable by the fetch stage for one cycle.
REQ-005 alu_res  output  32  ALU result for instr; also the register write-back data.
REQ-006 reg_write_en  output  1  high when instr is a supported instruction that writes a register.
REQ-007 reg_w  output  5  destination register index for instr.
REQ-008 dbg_addr  input  5  debug read-port index.
REQ-009 dbg_data  output  32  combinational contents of register dbg_addr; reads 0 for index 0.

Function
REQ-010 The block SHALL contain three sub-blocks: a decoder (control), a 32x32 register file and a 32-bit ALU.
REQ-011 Register file read ports SHALL be combinational: port 1 is indexed by instr[25:21] (rs), port 2 by instr[20:16] (rt).
REQ-012 Register 0 SHALL always read 0, and writes to it SHALL be discarded.
REQ-013 A write of alu_res to reg_w SHALL occur on a rising clk edge when reg_write_en=1 and reset=1.
REQ-014 There SHALL be no read bypass: a read of the register being written returns the old value until the edge.
REQ-015 R-type (opcode 0) SHALL use reg_w=instr[15:11] (rd), ALU B = rs2 data, and the operation selected by funct.
REQ-016 Supported R-type funct codes:
- add 0x20, addu 0x21, sub 0x22, subu 0x23
- and 0x24, or 0x25, xor 0x26, nor 0x27
- slt 0x2A, sltu 0x2B
- sll 0x00, srl 0x02, sra 0x03
REQ-017 Shifts SHALL shift the rt data by shamt instr[10:6]; the rs value is ignored.
REQ-018 I-type SHALL use reg_w=instr[20:16] (rt) and ALU B = extended imm16 instr[15:0].
REQ-019 Supported I-type opcodes:
- sign-extended imm: addi 0x08, addiu 0x09, slti 0x0A, sltiu 0x0B
- zero-extended imm: andi 0x0C, ori 0x0D, xori 0x0E
- lui 0x0F: result = {imm16, 16'h0}
REQ-020 add/addi/sub SHALL wrap modulo 2^32; there is no overflow trap, and the write still occurs.
REQ-021 slt/slti SHALL compare signed; sltu/sltiu SHALL compare unsigned, including the sign-extended imm; the result is 32'd1 or 32'd0.
REQ-022 Any other opcode or funct SHALL drive reg_write_en=0, reg_w=0 and alu_res=0.
REQ-023 alu_res, reg_write_en and reg_w SHALL be purely combinational from instr and register state, with zero-cycle latency.
REQ-024 The internal alu_op code SHALL be 6 bits, equal to the funct value for R-type and to a decoder-mapped funct equivalent for I-type.

Reset
REQ-025 While reset=0, all 31 writable registers SHALL read 0, and writes SHALL be blocked.
REQ-026 Assertion of reset SHALL clear the registers without waiting for clk, including mid-cycle with reg_write_en=1.
REQ-027 Outputs SHALL stay combinational during reset; with instr=0 (sll $0,$0,0), alu_res=0, reg_write_en=1 and reg_w=0.

Verification
REQ-028 Immediates and I-type:
- reset, then addi $1,$0,5 (0x20010005) and one edge -> dbg_data[1]=5
- addi $2,$0,-1 (0x2002FFFF) -> dbg_data[2]=0xFFFFFFFF
REQ-029 R-type arithmetic and compares:
- add $3,$1,$2 (0x00221820) -> 4
- sub $4,$1,$2 -> 6
- slt $5,$2,$1 -> 1
- sltu $6,$2,$1 -> 0
REQ-030 Logic, lui and shifts:
- ori $7,$0,0xFFFF -> 0x0000FFFF
- lui $8,0x8000 -> 0x80000000
- sra $9,$8,4 -> 0xF8000000
- srl $10,$8,4 -> 0x08000000
REQ-031 Zero register and overflow:
- addi $0,$0,7 -> dbg_data[0]=0
- add with 0x7FFFFFFF+1 -> 0x80000000, written with no trap
REQ-032 Unsupported and reset:
- opcode 0x3F -> reg_write_en=0 and no register changes
- assert reset mid-cycle -> all dbg_data reads return 0 before the next clk edge
